// File: rtl/regfile_dumper_if.sv
// Stream-side bundle for the register-file dumper.
// One beat = {index, data, last} on a valid/ready handshake.
interface regfile_dumper_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              m_valid;
   logic              m_ready;
   logic [ADDR_W-1:0] m_index;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      output m_valid,
      output m_index,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_index,
      input  m_data,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/regfile_dumper.sv
// Debug read-out engine: walks a register-file index range
// and streams each register as an {index, data} beat.
module regfile_dumper #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_idx,
   input  logic [ADDR_W-1:0] last_idx,
   input  logic              abort,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   regfile_dumper_if.master  m,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ONE = 1;

   state_t            r_state;
   state_t            w_nstate;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_end;
   logic [ADDR_W-1:0] r_index;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;
   logic              w_load;
   logic              w_cap;
   logic              w_adv;

   always_comb begin
      w_nstate = r_state;
      w_load   = 1'b0;
      w_cap    = 1'b0;
      w_adv    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nstate = S_FETCH;
               w_load   = 1'b1;
            end
         end
         S_FETCH: begin
            w_nstate = S_SEND;
            w_cap    = 1'b1;
         end
         S_SEND: begin
            if (m.m_ready) begin
               w_nstate = r_last ? S_DONE : S_FETCH;
               w_adv    = !r_last;
            end
         end
         S_DONE: w_nstate = S_IDLE;
         default: w_nstate = S_IDLE;
      endcase
      // abort outranks start and m_ready; the in-flight beat is dropped
      if (abort && r_state != S_IDLE) begin
         w_nstate = S_IDLE;
         w_cap    = 1'b0;
         w_adv    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_end   <= '0;
         r_index <= '0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_valid <= (w_nstate == S_SEND);
         r_busy  <= (w_nstate != S_IDLE);
         r_done  <= (w_nstate == S_DONE);
         if (w_load) begin
            r_idx <= first_idx;
            r_end <= last_idx;
         end
         if (w_cap) begin
            r_data  <= rf_data;
            r_index <= r_idx;
            r_last  <= (r_idx == r_end);
         end
         if (w_adv) begin
            r_idx <= r_idx + ONE;
         end
      end
   end

   assign rf_addr   = (r_state == S_FETCH) ? r_idx : '0;
   assign m.m_valid = r_valid;
   assign m.m_index = r_index;
   assign m.m_data  = r_data;
   assign m.m_last  = r_last;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper with a beat scoreboard.
// Drive and sample on the falling edge of clk.
module tb_regfile_dumper;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  first_idx;
   logic [4:0]  last_idx;
   logic        abort;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        busy;
   logic        done;

   logic [31:0] regs [32];
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   regfile_dumper_if #(.ADDR_W(5), .DATA_W(32)) mif ();

   regfile_dumper #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .first_idx (first_idx),
      .last_idx  (last_idx),
      .abort     (abort),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .m         (mif.master),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rf_data = regs[rf_addr];

   // writes commit at the clock edge, after the read is sampled
   always @(posedge clk) begin
      if (wr_en) regs[wr_addr] <= wr_data;
   end

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t q[$];
   int    n_checks;
   int    n_pass;
   int    n_fail;
   int    pct;
   logic [5:0] stall_idx;
   logic  prev_stall;
   beat_t prev_beat;
   int    cyc;
   int    done_seen;
   int    done_cyc;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic  hold;
      beat_t cur;
      beat_t e;
      @(negedge clk);
      cyc++;
      hold = mif.m_valid && ({1'b0, mif.m_index} == stall_idx);
      mif.m_ready = ($urandom_range(99) < pct) && !hold;
      cur = '{mif.m_index, mif.m_data, mif.m_last};
      if (prev_stall) begin
         chk("hold_valid", mif.m_valid, 1'b1);
         chk("hold_beat", cur, prev_beat);
      end
      if (mif.m_valid && mif.m_ready) begin
         chk("beat_expected", q.size() != 0, 1'b1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("beat_index", cur.idx, e.idx);
            chk("beat_data", cur.data, e.data);
            chk("beat_last", cur.last, e.last);
         end
      end
      prev_stall = mif.m_valid && !mif.m_ready;
      prev_beat  = cur;
      if (done) begin
         done_seen++;
         done_cyc = cyc;
      end
   endtask

   task automatic push_exp(input logic [4:0] f,
                           input logic [4:0] l);
      logic [4:0] i;
      i = f;
      forever begin
         q.push_back('{i, regs[i], i == l});
         if (i == l) break;
         i = i + 5'd1;
      end
   endtask

   task automatic run_dump(input logic [4:0] f,
                           input logic [4:0] l,
                           input int rdy,
                           input bit snap,
                           input int exp_done);
      push_exp(f, l);
      pct       = rdy;
      first_idx = f;
      last_idx  = l;
      start     = 1'b1;
      cyc       = 0;
      done_seen = 0;
      done_cyc  = -1;
      for (int k = 0; k < 600; k++) begin
         tick();
         start = 1'b0;
         wr_en = 1'b0;
         if (snap && cyc == 1) begin
            chk("snap_rf_addr", rf_addr, f);
            wr_en   = 1'b1;
            wr_addr = f;
            wr_data = 32'hDEADBEEF;
         end
         if (done_seen != 0) break;
      end
      chk("dump_done", done_seen, 1);
      chk("dump_drained", q.size(), 0);
      if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
      // start during DONE must be ignored
      first_idx = 5'd9;
      last_idx  = 5'd9;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("post_done_busy", busy, 1'b0);
      chk("post_done_valid", mif.m_valid, 1'b0);
      chk("single_done", done_seen, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, mif.m_valid, 1'b0);
      chk({tag, "_index"}, mif.m_index, 5'd0);
      chk({tag, "_data"}, mif.m_data, 32'd0);
      chk({tag, "_last"}, mif.m_last, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_rf_addr"}, rf_addr, 5'd0);
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      n_fail      = 0;
      pct         = 100;
      stall_idx   = 6'h3f;
      prev_stall  = 1'b0;
      prev_beat   = '0;
      cyc         = 0;
      done_seen   = 0;
      done_cyc    = -1;
      rst_n       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      first_idx   = '0;
      last_idx    = '0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      mif.m_ready = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] = i * 32'h11111111;

      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_dump(5'd0, 5'd31, 100, 1'b0, 65);
      run_dump(5'd30, 5'd1, 100, 1'b0, 9);
      run_dump(5'd7, 5'd7, 100, 1'b0, 3);
      run_dump(5'd0, 5'd31, 30, 1'b0, -1);
      run_dump(5'd5, 5'd5, 100, 1'b1, 3);
      run_dump(5'd5, 5'd5, 100, 1'b0, 3);

      // abort during SEND of index 3, with a start in the same cycle
      push_exp(5'd0, 5'd10);
      pct       = 100;
      stall_idx = 6'd3;
      first_idx = 5'd0;
      last_idx  = 5'd10;
      start     = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         start = 1'b0;
         if (mif.m_valid && mif.m_index == 5'd3) break;
      end
      chk("abort_at_idx3", {mif.m_valid, mif.m_index}, {1'b1, 5'd3});
      abort      = 1'b1;
      start      = 1'b1;
      first_idx  = 5'd20;
      last_idx   = 5'd20;
      prev_stall = 1'b0;
      stall_idx  = 6'h3f;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_valid", mif.m_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      tick();
      chk("abort_start_ignored", busy, 1'b0);
      chk("abort_no_done", done_seen, 0);
      q.delete();
      prev_stall = 1'b0;
      run_dump(5'd2, 5'd4, 100, 1'b0, 7);

      // asynchronous reset while a beat is stalled in SEND
      push_exp(5'd0, 5'd31);
      pct       = 0;
      first_idx = 5'd0;
      last_idx  = 5'd31;
      start     = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         start = 1'b0;
         if (mif.m_valid) break;
      end
      chk("rst_pre_valid", mif.m_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_idle_busy", busy, 1'b0);
      chk("rst_idle_valid", mif.m_valid, 1'b0);
      run_dump(5'd31, 5'd0, 100, 1'b0, 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
